tick_serializer: RTL
====================

Name: tick_serializer

Overview:
- Serial framer that sits directly downstream of the divide-by-8 counter stage.
- Accepts a parallel word over a valid/ready handshake and shifts it out LSB-first as an asynchronous-serial frame: start bit, data, optional even-parity bit, stop bit(s).
- Each bit lasts exactly one tick period. i_tick is driven by the divider's terminal-count pulse (o_count_end), i.e. one clk-wide pulse every 8 clk.
- Everything runs on the single system clock; the divided clock is never used as a clock.

Parameters:
DATA_W, 8, data word width (legal 5..16)
PARITY_EN, 0, 1 = append even-parity bit after data
STOP_BITS, 1, number of stop bits (legal 1 or 2)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
i_tick  input  1  one-clk bit-rate strobe from divider terminal count
i_data  input  DATA_W  word to transmit; sampled only on accept
i_valid  input  1  upstream word valid
o_ready  output  1  block can accept a word (high only in IDLE)
o_serial  output  1  registered serial line, idle high
o_busy  output  1  high whenever state != IDLE
o_done  output  1  one-clk pulse at end of frame

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (resetn). All state is in flops on posedge clk / negedge resetn.
- Reset values: state=IDLE, o_serial=1, o_ready=1, o_busy=0, o_done=0, shift register=0, bit index=0, stop count=0.
- Accept: in IDLE, i_valid=1 latches i_data into the shift register and moves to ARM. o_ready drops next cycle. i_valid while not IDLE is ignored; no data is taken.
- States (all transitions only on a clk edge with i_tick=1, except IDLE->ARM):
  - IDLE: o_serial=1. Exits on accept.
  - ARM: o_serial=1. On tick -> START, o_serial=0.
  - START: on tick -> DATA, idx=0, o_serial=data[0].
  - DATA: on tick, if idx<DATA_W-1 -> idx+1 and o_serial=data[idx+1]. Otherwise -> PARITY (PARITY_EN=1) with o_serial=^data, or -> STOP with o_serial=1.
  - PARITY: on tick -> STOP, o_serial=1.
  - STOP: on tick, if stop count<STOP_BITS-1 -> count+1 and stay. Otherwise -> IDLE, o_done=1 for exactly one cycle, o_ready=1 that same cycle.
- ARM exists so every bit, including the start bit, spans exactly one full tick period. Latency from accept to start-bit falling edge is 1..8 clk with a tick every 8 clk.
- o_serial is registered and changes the cycle after the tick that causes the transition.
- Tick in the same cycle as accept: consumed by nothing. The block is in ARM only from the next cycle and waits for the next tick.
- Tick in IDLE is ignored.
- Back-to-back: with i_valid held high, the next word is accepted in the first IDLE cycle (the o_done cycle). A new frame therefore starts no sooner than one tick after the previous stop bit ends.
- Parity is even: the parity bit is XOR of the latched data bits.
- Reset asserted mid-frame: immediate return to reset values, o_serial=1, no o_done pulse.
- Index and counters are sized to hold DATA_W-1 and STOP_BITS-1 exactly. No wrap is reachable with legal parameters.

Test Plan:
- Defaults, tick every 8 clk, i_data=8'hA5 accepted -> o_serial sequence 0,1,0,1,0,0,1,0,1,1, each bit held 8 clk. o_done pulses 1 clk when the stop bit ends. o_busy high from accept+1 until the o_done cycle.
- PARITY_EN=1, STOP_BITS=2, i_data=8'h07 -> 0,1,1,1,0,0,0,0,0, parity 1, stop 1,1. o_done after 12 tick periods from the start bit.
- Accept coincident with i_tick -> start bit falls on the following tick, 8 clk after accept, not on the coincident tick.
- i_valid pulsed with i_data=8'hFF during the DATA state of an 8'h00 frame -> frame unchanged (all data bits 0), second word not accepted, o_ready remains 0.
- i_valid held high with words 8'h01 then 8'h80 -> second accept in the o_done cycle. Second start bit occurs one tick period after the first frame's stop bit ends.
- resetn pulsed low during data bit 3 -> o_serial=1 and o_ready=1 asynchronously, no o_done. A following 8'h3C frame transmits correctly.

Source files
------------

// File: rtl/tick_serializer.sv
// Async-serial framer: start bit, LSB-first data, optional even parity, stop bit(s).
// One bit per i_tick period. The ARM state aligns the start bit to a full tick period.
module tick_serializer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_tick,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_serial,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic STOP_LAST = (STOP_BITS > 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_inc;
  logic              stop_q, stop_d;
  logic              serial_q, serial_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    idx_inc  = idx_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        // A tick coinciding with accept is deliberately not consumed here.
        serial_d = 1'b1;
        if (i_valid) begin
          sr_d    = i_data;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (i_tick) begin
          state_d  = S_START;
          serial_d = 1'b0;
        end
      end
      S_START: begin
        if (i_tick) begin
          state_d  = S_DATA;
          idx_d    = '0;
          serial_d = sr_q[0];
        end
      end
      S_DATA: begin
        if (i_tick) begin
          if (idx_q < IDX_LAST) begin
            idx_d    = idx_inc;
            serial_d = sr_q[idx_inc];
          end else if (PARITY_EN != 0) begin
            state_d  = S_PARITY;
            serial_d = ^sr_q;
          end else begin
            state_d  = S_STOP;
            stop_d   = 1'b0;
            serial_d = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (i_tick) begin
          state_d  = S_STOP;
          stop_d   = 1'b0;
          serial_d = 1'b1;
        end
      end
      S_STOP: begin
        if (i_tick) begin
          if (stop_q < STOP_LAST) begin
            stop_d = stop_q + 1'b1;
          end else begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_busy   = (state_q != S_IDLE);
  assign o_serial = serial_q;
  assign o_done   = done_q;

endmodule
